// File: rtl/alu_ctrl_pkg.sv
// Shared types and sizes for the ALU request arbiter: FSM encoding,
// requester count, mux-select width and wait-counter width.
package alu_ctrl_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Requester/ALU handshake bundle between the arbiter and its environment.
interface alu_rr_arbiter_if;
    import alu_ctrl_pkg::*;

    logic [N_REQ-1:0] req;
    logic             alu_done;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             alu_start;
    logic [N_REQ-1:0] done;
    logic             timeout_err;
    logic             busy;

    modport master (
        output req, alu_done,
        input  gnt, sel, alu_start, done, timeout_err, busy
    );

    modport slave (
        input  req, alu_done,
        output gnt, sel, alu_start, done, timeout_err, busy
    );

endinterface

// File: rtl/rr_pick4.sv
// Rotated first-set search over four request bits, starting at ptr and
// wrapping upward. Purely combinational.
module rr_pick4
    import alu_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             found_c_o,
    output logic [SEL_W-1:0] idx_c_o
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest offset down so the nearest set bit wins.
    always_comb begin
        found_c_o = 1'b0;
        idx_c_o   = '0;
        cand      = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            cand = ptr_i + SEL_W'(i);
            if (req_i[cand]) begin
                found_c_o = 1'b1;
                idx_c_o   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among four requesters:
// grants, pulses alu_start, holds until alu_done or timeout, then rotates.
module alu_rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_rr_arbiter_if.slave  bus
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             tout_q, tout_d;
    logic             busy_q, busy_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [CNT_W-1:0] cnt_inc;

    rr_pick4 u_pick (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .found_c_o (pick_found),
        .idx_c_o   (pick_idx)
    );

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
        end
    end

    // Forced release lands TIMEOUT cycles after the alu_start pulse;
    // alu_done wins when both happen in the same WAIT cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        done_d  = '0;
        tout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.alu_done) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                    state_d = ST_IDLE;
                end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.gnt         = gnt_q;
    assign bus.sel         = sel_q;
    assign bus.alu_start   = start_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = tout_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: table of grant operations with
// hand-derived expectations, a completion scoreboard, and reset corner cases.
module tb_alu_rr_arbiter;

    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic [3:0] req;
        int         dly;   // WAIT cycle (1-based) carrying alu_done; 0 = never
        bit         hold;  // keep req high after release
        bit         drop;  // grantee drops req in the first WAIT cycle
        logic [3:0] gnt;
        logic [1:0] sel;
        bit         tout;
    } vec_t;

    typedef struct {
        logic [3:0] done;
        bit         tout;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_rr_arbiter_if bus ();

    alu_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_start = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_chk++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion scoreboard: every done/timeout pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (bus.alu_start) n_start++;
        if (bus.done != 4'b0 || bus.timeout_err) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'({bus.done, bus.timeout_err}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_done", 32'(bus.done), 32'(mon_e.done));
                chk("sb_tout", 32'(bus.timeout_err), 32'(mon_e.tout));
            end
        end
    end

    task automatic run_op(input vec_t v);
        exp_t e;
        e.done = v.tout ? 4'b0 : v.gnt;
        e.tout = v.tout;
        chk("gap_gnt", 32'(bus.gnt), 32'd0);
        bus.req = v.req;
        exp_q.push_back(e);
        step();
        chk("gnt", 32'(bus.gnt), 32'(v.gnt));
        chk("sel", 32'(bus.sel), 32'(v.sel));
        chk("alu_start", 32'(bus.alu_start), 32'd1);
        chk("busy", 32'(bus.busy), 32'd1);
        step();
        chk("start_pulse_len", 32'(bus.alu_start), 32'd0);
        for (int j = 1; j < int'(TIMEOUT); j++) begin
            if (v.drop && j == 1) bus.req = 4'b0;
            bus.alu_done = (j == v.dly);
            chk("gnt_held", 32'(bus.gnt), 32'(v.gnt));
            step();
            bus.alu_done = 1'b0;
            if (j == v.dly || j == int'(TIMEOUT) - 1) begin
                chk("rel_gnt", 32'(bus.gnt), 32'd0);
                chk("rel_busy", 32'(bus.busy), 32'd0);
                chk("rel_done", 32'(bus.done), 32'(e.done));
                chk("rel_tout", 32'(bus.timeout_err), 32'(e.tout));
                break;
            end
        end
        if (!v.hold) bus.req = 4'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_base;
        vec_t v;

        //           req      dly hold drop gnt      sel   tout
        vecs[0]  = '{4'b0100, 3,  1'b0, 1'b0, 4'b0100, 2'd2, 1'b0};
        vecs[1]  = '{4'b0011, 1,  1'b0, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[2]  = '{4'b0011, 2,  1'b0, 1'b0, 4'b0010, 2'd1, 1'b0};
        vecs[3]  = '{4'b0101, 1,  1'b0, 1'b0, 4'b0100, 2'd2, 1'b0};
        vecs[4]  = '{4'b1001, 1,  1'b0, 1'b0, 4'b1000, 2'd3, 1'b0};
        vecs[5]  = '{4'b1111, 2,  1'b1, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[6]  = '{4'b1111, 2,  1'b1, 1'b0, 4'b0010, 2'd1, 1'b0};
        vecs[7]  = '{4'b1111, 2,  1'b1, 1'b0, 4'b0100, 2'd2, 1'b0};
        vecs[8]  = '{4'b1111, 2,  1'b1, 1'b0, 4'b1000, 2'd3, 1'b0};
        vecs[9]  = '{4'b1111, 2,  1'b0, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[10] = '{4'b0010, 0,  1'b0, 1'b0, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{4'b0110, 1,  1'b0, 1'b0, 4'b0100, 2'd2, 1'b0};
        vecs[12] = '{4'b0010, 15, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0};
        vecs[13] = '{4'b1010, 5,  1'b0, 1'b1, 4'b1000, 2'd3, 1'b0};

        rst_n        = 1'b0;
        bus.req      = 4'b0;
        bus.alu_done = 1'b0;
        start_base   = 0;
        repeat (2) step();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_start", 32'(bus.alu_start), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_tout", 32'(bus.timeout_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            if (i == 5) start_base = n_start;
            run_op(vecs[i]);
            if (i == 9) chk("round_starts", 32'(n_start - start_base), 32'd5);
        end

        // Reset in the middle of WAIT: immediate clear, no done pulse.
        bus.req = 4'b0100;
        step();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'b0100);
        chk("pre_rst_sel", 32'(bus.sel), 32'd2);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(bus.gnt), 32'd0);
        chk("async_sel", 32'(bus.sel), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_start", 32'(bus.alu_start), 32'd0);
        chk("async_done", 32'(bus.done), 32'd0);
        bus.req = 4'b0;
        step();
        step();
        chk("in_rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;

        // Idle with no requests stays idle.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_busy", 32'({bus.busy, bus.gnt, bus.alu_start}), 32'd0);
        end

        v = '{4'b1000, 2, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0};
        run_op(v);
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
